aes_param_core: RTL and testbench
=================================

Name: aes_param_core

Overview:
Parametrised word-serial AES encryption core supporting AES-128/192/256 via key length NK.
- Takes cipher key and plaintext on one 32-bit valid/ready input stream.
- Expands and stores the full key schedule once, then encrypts any number of blocks under that key.
- Returns ciphertext on a 32-bit valid/ready output stream.
- Successor to the fixed AES-128 top: adds key-size selection, flow control and key reuse across blocks.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4/6/8; NR = NK+6 rounds.
- NW, 4*(NK+7), derived (localparam): round-key words stored (44/52/60).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dword_in  in  32  key or plaintext word; word i = state column i, bits [31:24] = row 0 (FIPS-197 byte order).
- in_is_key  in  1  qualifies dword_in: 1 = key word, 0 = plaintext word.
- in_valid  in  1  input word present.
- in_ready  out  1  core accepts a word this cycle.
- dword_out  out  32  ciphertext word, column order 0..3.
- out_valid  out  1  dword_out valid.
- out_ready  in  1  downstream accepts.
- key_valid  out  1  a full key schedule is stored.
- proto_err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Transfer occurs when valid&ready are high at a rising edge, on both streams.
- Reset value of every output is 0; reset also forces IDLE, clears key_valid, all counters and the state register. Reset mid-operation discards any partial key or block.
- FSM states:
  - IDLE: in_ready=1. A key word goes to KEY_LOAD. A data word is dropped and proto_err pulses.
  - KEY_LOAD: in_ready=1. Accepts NK key words into rk[0..NK-1], then goes to KEY_EXP. A data word here is dropped, proto_err pulses, and the partial key is kept.
  - KEY_EXP: in_ready=0. Computes one word per cycle for rk[NK..NW-1] (NW-NK cycles), then goes to READY with key_valid=1.
    - Standard schedule: if i%NK==0, temp = SubWord(RotWord(rk[i-1])) ^ Rcon[i/NK].
    - If NK==8 and i%8==4, temp = SubWord(rk[i-1]).
    - Otherwise temp = rk[i-1].
    - Result: rk[i] = rk[i-NK] ^ temp.
  - READY: in_ready=1. A data word goes to DATA_LOAD with word 0 latched. A key word clears key_valid, goes to KEY_LOAD and counts as key word 0.
  - DATA_LOAD: Accepts words 1..3. Each word is stored XORed with rk[word_idx], which fuses round 0 AddRoundKey. A key word here aborts the block (proto_err pulses) and is taken as key word 0 of a new key.
  - ROUND: in_ready=0. Processes one column per cycle, 4 cycles per round, rounds 1..NR.
    - new_col[c] = MixColumns(SubBytes(ShiftRows-gathered bytes of the old state)) ^ rk[4r+c].
    - MixColumns is bypassed when r==NR.
    - Results are written to a shadow register; the state is swapped at the end of each round.
  - OUT: out_valid=1. Presents words 0..3 and holds dword_out stable while out_ready=0. After word 3 transfers, returns to READY.
- Latency: first input word accepted to first out_valid = 4 + 4*NR cycles (44/52/60). Key ready = NK + (NW-NK) cycles after the first key word.
- Boundaries:
  - Word counters wrap 3→0.
  - The round counter stops at NR.
  - in_valid during KEY_EXP, ROUND or OUT is not consumed (in_ready=0) and is not an error.
- Rcon is a 10-entry constant, indexed 1..10; NK=4 uses up to index 10.

Optional Feature:
- AES_DBG_STATE_EN.
- Defined: adds output ports dbg_state[127:0] (current state register, column 0 in bits [127:96]), dbg_round[3:0] and dbg_fsm[2:0].
- Undefined: these ports and their logic are absent; functional behaviour is identical.

Decomposition:
- Package aes_pkg holds:
  - FSM state enum (IDLE, KEY_LOAD, KEY_EXP, READY, DATA_LOAD, ROUND, OUT).
  - RCON array.
  - Functions gather_col(state, c) for the ShiftRows byte select, and xtime.
- Existing s_box (32-bit) and MixColumns blocks are reused: one s_box for the key schedule, one for the datapath.
- One natural sub-module: aes_key_sched (rk storage array, expansion counter, read port rk_rd(idx)).

Test Plan:
- NK=4, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d8 6a7b0430 d8cdb780 70b4c55a; first out_valid exactly 44 cycles after the first pt word.
- NK=6, key 00..17, same pt -> ct dda97ca4 864cdfe0 6eaf70a0 ec0d7191; NK=8, key 00..1f -> 8ea2b7ca 516745bf eafc4990 4b496089.
- NK=4: two back-to-back blocks under one key, out_ready low for 5 cycles mid-output -> both ciphertexts correct, dword_out stable while stalled, no reload needed.
- Data word in IDLE -> proto_err high 1 cycle, key_valid stays 0, no output; key word after 2 data words of a block -> proto_err pulse, block discarded, new key loads correctly.
- Reset asserted during ROUND (round 5) -> next cycle all outputs 0, key_valid 0; fresh key+pt then yields the correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared FSM type, round constants and byte helpers for aes_param_core
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEY_LOAD,
    KEY_EXP,
    READY,
    DATA_LOAD,
    ROUND,
    OUT
  } state_e;

  // Round constants, indexed by i/NK of the schedule word being generated
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // ShiftRows byte select: row r of output column c comes from column (c+r)%4
  function automatic logic [31:0] gather_col(input logic [127:0] st, input logic [1:0] c);
    logic [31:0] col;
    int          j;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      j = (int'(c) + r) % 4;
      col[31-8*r -: 8] = st[127-32*j-8*r -: 8];
    end
    return col;
  endfunction

endpackage

// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - round-key storage with word-serial expansion and one read port
module aes_key_sched import aes_pkg::*; #(
  parameter int NK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_en_i,
  input  logic [2:0]  ld_idx_i,
  input  logic [31:0] ld_data_i,
  input  logic        exp_en_i,
  output logic        exp_last_o,
  input  logic [5:0]  rd_idx_i,
  output logic [31:0] rd_data_o
);

  localparam int NW = 4 * (NK + 7);

  logic [31:0] rk_q [NW];
  logic [5:0]  exp_idx_q;
  logic [2:0]  exp_mod_q;   // exp_idx_q % NK, tracked incrementally
  logic [3:0]  rcon_idx_q;  // exp_idx_q / NK
  logic [31:0] prev_w, sub_in, sub_out, temp_w;

  assign prev_w     = rk_q[exp_idx_q - 6'd1];
  assign sub_in     = (exp_mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign exp_last_o = (exp_idx_q == 6'(NW - 1));
  assign rd_data_o  = rk_q[rd_idx_i];

  aes_sbox32 u_sbox (.word_i(sub_in), .word_o(sub_out));

  // Schedule word transform selected by position within the key period
  always_comb begin
    temp_w = prev_w;
    if (exp_mod_q == 3'd0)
      temp_w = sub_out ^ {RCON[rcon_idx_q], 24'h000000};
    else if (NK == 8 && exp_mod_q == 3'd4)
      temp_w = sub_out;
  end

  // Key storage: loaded words from the input stream, otherwise expansion results
  always_ff @(posedge clk) begin
    if (ld_en_i)
      rk_q[{3'b000, ld_idx_i}] <= ld_data_i;
    else if (exp_en_i)
      rk_q[exp_idx_q] <= rk_q[exp_idx_q - 6'(NK)] ^ temp_w;
  end

  // Expansion counters, parked at word NK whenever expansion is idle
  always_ff @(posedge clk) begin
    if (reset || !exp_en_i) begin
      exp_idx_q  <= 6'(NK);
      exp_mod_q  <= 3'd0;
      rcon_idx_q <= 4'd1;
    end else begin
      exp_idx_q <= exp_idx_q + 6'd1;
      if (exp_mod_q == 3'(NK - 1)) begin
        exp_mod_q  <= 3'd0;
        rcon_idx_q <= rcon_idx_q + 4'd1;
      end else begin
        exp_mod_q <= exp_mod_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/aes_mix_col.sv
// rtl/aes_mix_col.sv - MixColumns on one state column (row 0 in bits [31:24])
module aes_mix_col import aes_pkg::*; (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_i;
  assign col_o[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign col_o[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/aes_sbox32.sv
// rtl/aes_sbox32.sv - four parallel AES S-boxes on one 32-bit word
module aes_sbox32 import aes_pkg::*; (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform
  function automatic logic [7:0] sbox8(input logic [7:0] a);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign word_o = {sbox8(word_i[31:24]), sbox8(word_i[23:16]),
                   sbox8(word_i[15:8]),  sbox8(word_i[7:0])};

endmodule

// File: rtl/aes_param_core.sv
// rtl/aes_param_core.sv - word-serial AES-128/192/256 encryptor; AES_DBG_STATE_EN adds debug ports
module aes_param_core import aes_pkg::*; #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  dword_in,
  input  logic         in_is_key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  dword_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         key_valid,
`ifdef AES_DBG_STATE_EN
  output logic [127:0] dbg_state,
  output logic [3:0]   dbg_round,
  output logic [2:0]   dbg_fsm,
`endif
  output logic         proto_err
);

  localparam int NR = NK + 6;

  state_e       state_q, state_d;
  logic [2:0]   kw_q;
  logic [1:0]   word_q;     // load index, round column and output index
  logic [3:0]   round_q;
  logic [127:0] st_q;
  logic [31:0]  sh_q [3];   // columns 0..2 of the round in progress
  logic         key_valid_q, proto_err_q;
  logic         in_fire, key_fire, data_fire, out_fire, exp_last;
  logic [5:0]   rd_idx;
  logic [2:0]   ld_idx;
  logic [31:0]  rk_word, gath, sub_col, mix_col, new_col;

  assign in_fire   = in_valid & in_ready;
  assign key_fire  = in_fire & in_is_key;
  assign data_fire = in_fire & ~in_is_key;
  assign out_fire  = out_valid & out_ready;
  assign ld_idx    = (state_q == KEY_LOAD) ? kw_q : 3'd0;
  assign rd_idx    = (state_q == ROUND) ? {round_q, word_q} : {4'd0, word_q};

  aes_key_sched #(.NK(NK)) u_key_sched (
    .clk       (clk),
    .reset     (reset),
    .ld_en_i   (key_fire),
    .ld_idx_i  (ld_idx),
    .ld_data_i (dword_in),
    .exp_en_i  (state_q == KEY_EXP),
    .exp_last_o(exp_last),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rk_word)
  );

  assign gath = gather_col(st_q, word_q);
  aes_sbox32  u_sbox (.word_i(gath), .word_o(sub_col));
  aes_mix_col u_mix  (.col_i(sub_col), .col_o(mix_col));
  assign new_col = ((round_q == 4'(NR)) ? sub_col : mix_col) ^ rk_word;

  assign key_valid = key_valid_q;
  assign proto_err = proto_err_q;

`ifdef AES_DBG_STATE_EN
  assign dbg_state = st_q;
  assign dbg_round = round_q;
  assign dbg_fsm   = state_q;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (key_fire) state_d = KEY_LOAD;
      KEY_LOAD:  if (key_fire && kw_q == 3'(NK - 1)) state_d = KEY_EXP;
      KEY_EXP:   if (exp_last) state_d = READY;
      READY:     if (key_fire) state_d = KEY_LOAD;
                 else if (data_fire) state_d = DATA_LOAD;
      DATA_LOAD: if (key_fire) state_d = KEY_LOAD;
                 else if (data_fire && word_q == 2'd3) state_d = ROUND;
      ROUND:     if (word_q == 2'd3 && round_q == 4'(NR)) state_d = OUT;
      OUT:       if (out_fire && word_q == 2'd3) state_d = READY;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs; nothing is accepted while reset is held
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dword_out = 32'h0;
    case (state_q)
      IDLE, KEY_LOAD, READY, DATA_LOAD: in_ready = ~reset;
      OUT: begin
        out_valid = 1'b1;
        dword_out = st_q[127-32*word_q -: 32];
      end
      default: ;
    endcase
  end

  // Counters, cipher state, shadow columns and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      kw_q        <= 3'd0;
      word_q      <= 2'd0;
      round_q     <= 4'd0;
      st_q        <= '0;
      sh_q        <= '{default: '0};
      key_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_fire)       kw_q <= 3'd1;
          else if (data_fire) proto_err_q <= 1'b1;
        end
        KEY_LOAD: begin
          if (key_fire)       kw_q <= (kw_q == 3'(NK - 1)) ? 3'd0 : kw_q + 3'd1;
          else if (data_fire) proto_err_q <= 1'b1;
        end
        KEY_EXP: if (exp_last) key_valid_q <= 1'b1;
        READY: begin
          if (key_fire) begin
            key_valid_q <= 1'b0;
            kw_q        <= 3'd1;
          end else if (data_fire) begin
            st_q[127:96] <= dword_in ^ rk_word;
            word_q       <= 2'd1;
          end
        end
        DATA_LOAD: begin
          if (key_fire) begin
            proto_err_q <= 1'b1;
            key_valid_q <= 1'b0;
            kw_q        <= 3'd1;
            word_q      <= 2'd0;
          end else if (data_fire) begin
            st_q[127-32*word_q -: 32] <= dword_in ^ rk_word;
            word_q <= word_q + 2'd1;
            if (word_q == 2'd3) round_q <= 4'd1;
          end
        end
        ROUND: begin
          word_q <= word_q + 2'd1;
          if (word_q == 2'd3) begin
            st_q <= {sh_q[0], sh_q[1], sh_q[2], new_col};
            if (round_q != 4'(NR)) round_q <= round_q + 4'd1;
          end else begin
            sh_q[word_q] <= new_col;
          end
        end
        OUT: if (out_fire) word_q <= word_q + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_param_core.sv
// tb/tb_aes_param_core.sv - directed bench for aes_param_core at NK=4/6/8
module tb_aes_param_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dword_in;
  logic        in_is_key;
  logic        out_ready;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] dword_out [3];
  logic        out_valid [3];
  logic        key_valid [3];
  logic        proto_err [3];
`ifdef AES_DBG_STATE_EN
  logic [127:0] dbg_state [3];
  logic [3:0]   dbg_round [3];
  logic [2:0]   dbg_fsm   [3];
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_param_core #(.NK(4 + 2*g)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .dword_in (dword_in),
      .in_is_key(in_is_key),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .dword_out(dword_out[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .key_valid(key_valid[g]),
`ifdef AES_DBG_STATE_EN
      .dbg_state(dbg_state[g]),
      .dbg_round(dbg_round[g]),
      .dbg_fsm  (dbg_fsm[g]),
`endif
      .proto_err(proto_err[g])
    );
  end

  typedef struct {
    int            d;
    logic [255:0]  key;
    logic [127:0]  pt;
    logic [127:0]  ct;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    tests++;
    failed++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [31:0] w, input logic k);
    int n;
    n = 0;
    dword_in    = w;
    in_is_key   = k;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) expired("send_wait");
    tick();
    in_valid[d] = 1'b0;
  endtask

  task automatic load_key(input int d, input logic [255:0] key, input int first, output int lat);
    int nk, n;
    nk = 4 + 2*d;
    for (int i = first; i < nk; i++) send(d, key[255-32*i -: 32], 1'b1);
    n = nk - first;
    while (!key_valid[d] && n < 300) begin
      tick();
      n++;
    end
    if (!key_valid[d]) expired("key_wait");
    lat = n;
  endtask

  task automatic recv(input int d, input int stall_at, output logic [127:0] ct);
    int          n;
    logic [31:0] held;
    ct = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!out_valid[d] && n < 300) begin
        tick();
        n++;
      end
      if (!out_valid[d]) begin
        expired("recv_wait");
        return;
      end
      if (i == stall_at) begin
        held = dword_out[d];
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_hold", {out_valid[d], dword_out[d]}, {1'b1, held});
        end
        out_ready = 1'b1;
      end
      ct[127-32*i -: 32] = dword_out[d];
      tick();
    end
  endtask

  task automatic encrypt(input int d, input logic [127:0] pt, input int stall_at,
                         output logic [127:0] ct, output int lat);
    int n;
    for (int i = 0; i < 4; i++) send(d, pt[127-32*i -: 32], 1'b0);
    n = 4;
    while (!out_valid[d] && n < 400) begin
      tick();
      n++;
    end
    if (!out_valid[d]) expired("out_wait");
    lat = n;
    recv(d, stall_at, ct);
  endtask

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    vec_t         vecs [4];
    logic [127:0] ct;
    int           klat, dlat, nk;

    vecs[0] = '{d: 0, key: KEY_C1, pt: PT_C, ct: CT_C1};
    vecs[1] = '{d: 1, key: KEY_C2, pt: PT_C, ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[2] = '{d: 2, key: KEY_C3, pt: PT_C, ct: 128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[3] = '{d: 0, key: KEY_B,  pt: PT_B, ct: CT_B};

    reset     = 1'b1;
    dword_in  = 32'h0;
    in_is_key = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outputs_d%0d", i),
          {in_ready[i], out_valid[i], key_valid[i], proto_err[i], dword_out[i]}, '0);
    reset = 1'b0;
    tick();

    // Known-answer vectors with key-ready and block latency
    for (int v = 0; v < 4; v++) begin
      nk = 4 + 2*vecs[v].d;
      load_key(vecs[v].d, vecs[v].key, 0, klat);
      chk($sformatf("v%0d_key_latency", v), klat, 4*(nk+7));
      encrypt(vecs[v].d, vecs[v].pt, -1, ct, dlat);
      chk($sformatf("v%0d_out_latency", v), dlat, 4 + 4*(nk+6));
      chk($sformatf("v%0d_ciphertext", v), ct, vecs[v].ct);
    end

    // Two back-to-back blocks under the stored key, second one stalled mid-output
    encrypt(0, 128'h6bc1bee22e409f96e93d7e117393172a, -1, ct, dlat);
    chk("b2b_block0", ct, 128'h3ad77bb40d7a3660a89ecaf32466ef97);
    encrypt(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 2, ct, dlat);
    chk("b2b_block1", ct, 128'hf5d3d58503b9699de785895a96fdbaaf);
    chk("b2b_key_kept", key_valid[0], 1'b1);

    // Data word with no key loaded
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    send(0, 32'hdeadbeef, 1'b0);
    chk("idle_data_err", {proto_err[0], key_valid[0], out_valid[0]}, 3'b100);
    tick();
    chk("idle_err_pulse", {proto_err[0], key_valid[0], out_valid[0]}, 3'b000);

    // Key word aborts a half-loaded block and starts a new key
    load_key(0, KEY_C1, 0, klat);
    send(0, PT_C[127:96], 1'b0);
    send(0, PT_C[95:64], 1'b0);
    send(0, KEY_B[255:224], 1'b1);
    chk("abort_err", {proto_err[0], key_valid[0]}, 2'b10);
    tick();
    chk("abort_err_pulse", {proto_err[0], out_valid[0]}, 2'b00);
    load_key(0, KEY_B, 1, klat);
    chk("abort_newkey_latency", klat, 43);
    encrypt(0, PT_B, -1, ct, dlat);
    chk("abort_newkey_ct", ct, CT_B);

    // Reset in round 5, then a fresh key and block
    load_key(0, KEY_C1, 0, klat);
    for (int i = 0; i < 4; i++) send(0, PT_C[127-32*i -: 32], 1'b0);
    repeat (17) tick();
    chk("round_in_ready", {in_ready[0], out_valid[0]}, 2'b00);
    reset = 1'b1;
    tick();
    chk("midround_reset",
        {in_ready[0], out_valid[0], key_valid[0], proto_err[0], dword_out[0]}, '0);
    reset = 1'b0;
    tick();
    chk("post_reset_key_cleared", key_valid[0], 1'b0);
    load_key(0, KEY_C1, 0, klat);
    encrypt(0, PT_C, -1, ct, dlat);
    chk("post_reset_ct", ct, CT_C1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
